// File: rtl/conv_sram_host_if.sv
// -----------------------------------------------------------------------------
// conv_sram_host_if
//
// Purpose:
//   Bundles every signal exchanged between conv_sram_host and the parties
//   around it: the convolution engine (run/busy handshake and the SRAM read
//   and write strobes) and the system host (preload/unload port, run request
//   and run status).
//
// Modports:
//   slave  - view taken by conv_sram_host (drives dut_run, read data, status).
//   master - view taken by whoever plays engine and host (a testbench or the
//            surrounding system).
//
// Signals:
//   dut_run                 host -> engine  one-cycle start pulse
//   dut_busy                engine -> host  engine busy
//   dut_sram_read_address   engine -> host  engine read address
//   sram_dut_read_data      host -> engine  read data, one cycle after address
//   dut_sram_write_address  engine -> host  engine write address
//   dut_sram_write_data     engine -> host  engine write data
//   dut_sram_write_enable   engine -> host  engine write strobe
//   host_start              system -> host  request one run
//   host_we                 system -> host  host write strobe
//   host_addr               system -> host  host read/write address
//   host_wdata              system -> host  host write data
//   host_rdata              host -> system  host read data
//   host_done               host -> system  one-cycle pulse at end of a run
//   host_err                host -> system  sticky [0] busy timeout, [1] rejected access
//   host_cycles             host -> system  BUSY cycles in the last run (saturating)
//   host_wcount             host -> system  engine writes in the last run (saturating)
// -----------------------------------------------------------------------------
interface conv_sram_host_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // Engine side
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;

  // System host side
  logic              host_start;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_done;
  logic [1:0]        host_err;
  logic [31:0]       host_cycles;
  logic [ADDR_W:0]   host_wcount;

  modport slave (
    output dut_run,
    input  dut_busy,
    input  dut_sram_read_address,
    output sram_dut_read_data,
    input  dut_sram_write_address,
    input  dut_sram_write_data,
    input  dut_sram_write_enable,
    input  host_start,
    input  host_we,
    input  host_addr,
    input  host_wdata,
    output host_rdata,
    output host_done,
    output host_err,
    output host_cycles,
    output host_wcount
  );

  modport master (
    input  dut_run,
    output dut_busy,
    output dut_sram_read_address,
    input  sram_dut_read_data,
    output dut_sram_write_address,
    output dut_sram_write_data,
    output dut_sram_write_enable,
    output host_start,
    output host_we,
    output host_addr,
    output host_wdata,
    input  host_rdata,
    input  host_done,
    input  host_err,
    input  host_cycles,
    input  host_wcount
  );
endinterface

// File: rtl/conv_sram_host.sv
// -----------------------------------------------------------------------------
// conv_sram_host
//
// Purpose:
//   Far end of the convolution engine's SRAM and run/busy interfaces. Holds the
//   image memory (one synchronous read port, one synchronous write port,
//   read-first), arbitrates both ports between the system host (while idle)
//   and the engine (while a run is in progress), and runs the start/busy
//   handshake with timeouts, reporting completion, BUSY cycle count and engine
//   write count.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_b  in   asynchronous active-low reset (memory contents are kept)
//   bus      slave modport of conv_sram_host_if (engine + host signals)
//
// Parameters:
//   ADDR_W         word address width
//   DATA_W         word width
//   DEPTH          number of words, 2**ADDR_W (addresses wrap naturally)
//   START_TIMEOUT  WAIT cycles allowed for dut_busy to rise after dut_run
//   RUN_TIMEOUT    BUSY cycles allowed before the run is forced to end
// -----------------------------------------------------------------------------
module conv_sram_host #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 2 ** ADDR_W,
  parameter int START_TIMEOUT = 16,
  parameter int RUN_TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             reset_b,
  conv_sram_host_if.slave  bus
);

  localparam int WC_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WAIT = 3'd2,
    ST_BUSY = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_timer;
  logic [31:0]         w_timer_next;
  logic                w_timeout;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_host_rdata;
  logic [DATA_W-1:0]   r_dut_rdata;
  logic [1:0]          r_err;
  logic [31:0]         r_cycles;
  logic [WC_W-1:0]     r_wcount;

  // ---------------------------------------------------------------------------
  // Port arbitration: the host owns both memory ports only while IDLE.
  // ---------------------------------------------------------------------------
  logic                w_idle;
  logic                w_clear;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_raddr;
  logic                w_host_reject;
  logic                w_count_wr;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_clear       = w_idle & bus.host_start;
  assign w_mem_we      = w_idle ? bus.host_we    : bus.dut_sram_write_enable;
  assign w_waddr       = w_idle ? bus.host_addr  : bus.dut_sram_write_address;
  assign w_wdata       = w_idle ? bus.host_wdata : bus.dut_sram_write_data;
  assign w_raddr       = w_idle ? bus.host_addr  : bus.dut_sram_read_address;
  assign w_host_reject = ~w_idle & bus.host_we;

  // Engine writes in RUN land in memory but are not counted; the count only
  // covers the window in which the engine may legitimately be working.
  assign w_count_wr = bus.dut_sram_write_enable &
                      ((r_state == ST_WAIT) || (r_state == ST_BUSY) ||
                       (r_state == ST_DONE));

  // ---------------------------------------------------------------------------
  // Next-state logic. r_timer counts cycles spent in WAIT or BUSY and is
  // zeroed on every entry into those states.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (bus.host_start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_timer_next = '0;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // busy is honoured even on the last allowed WAIT cycle
        if (bus.dut_busy) begin
          w_state_next = ST_BUSY;
          w_timer_next = '0;
        end else if (r_timer == 32'(START_TIMEOUT - 1)) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_BUSY: begin
        if (!bus.dut_busy) begin
          w_state_next = ST_DONE;
        end else if (r_timer == 32'(RUN_TIMEOUT - 1)) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory write port. Not reset: image contents survive reset_b.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State, read-data and status registers.
  // The read sits in the same edge as the write, so a same-address access
  // returns the previous contents (read-first). Only the output owned by the
  // current state is loaded; the other one holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_host_rdata <= '0;
      r_dut_rdata  <= '0;
      r_err        <= '0;
      r_cycles     <= '0;
      r_wcount     <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;

      if (w_idle) begin
        r_host_rdata <= r_mem[w_raddr];
      end else begin
        r_dut_rdata  <= r_mem[w_raddr];
      end

      if (w_clear) begin
        r_err    <= '0;
        r_cycles <= '0;
        r_wcount <= '0;
      end else begin
        if (w_timeout) begin
          r_err[0] <= 1'b1;
        end
        if (w_host_reject) begin
          r_err[1] <= 1'b1;
        end
        if ((r_state == ST_BUSY) && (r_cycles != '1)) begin
          r_cycles <= r_cycles + 32'd1;
        end
        if (w_count_wr && (r_wcount != '1)) begin
          r_wcount <= r_wcount + WC_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. dut_run and host_done decode single-cycle states, so each can be
  // high for at most one cycle and both are low straight out of reset.
  // ---------------------------------------------------------------------------
  assign bus.dut_run            = (r_state == ST_RUN);
  assign bus.host_done          = (r_state == ST_DONE);
  assign bus.sram_dut_read_data = r_dut_rdata;
  assign bus.host_rdata         = r_host_rdata;
  assign bus.host_err           = r_err;
  assign bus.host_cycles        = r_cycles;
  assign bus.host_wcount        = r_wcount;

endmodule

// File: tb/tb_conv_sram_host.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_conv_sram_host
//
// Plays both the system host and the convolution engine around
// conv_sram_host. A plain array mirrors the memory; run outcomes (BUSY cycles,
// write count, error bits, done latency) are predicted from the engine
// behaviour chosen for each run.
// -----------------------------------------------------------------------------
module tb_conv_sram_host;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int START_TO = 16;
  localparam int RUN_TO   = 65535;

  logic clk;
  logic reset_b;

  conv_sram_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  conv_sram_host #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DEPTH        (2 ** ADDR_W),
    .START_TIMEOUT(START_TO),
    .RUN_TIMEOUT  (RUN_TO)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mdl [2 ** ADDR_W];

  // Pulse monitors, sampled away from the active edge.
  int   run_cnt  = 0;
  int   run_long = 0;
  int   done_cnt = 0;
  logic prev_run = 1'b0;

  always @(negedge clk) begin
    if (bus.dut_run === 1'b1) run_cnt++;
    if (bus.dut_run === 1'b1 && prev_run === 1'b1) run_long++;
    prev_run = bus.dut_run;
    if (bus.host_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    tick();
    bus.host_we    = 1'b0;
    mdl[a]         = d;
  endtask

  task automatic host_read(input string tag, input logic [ADDR_W-1:0] a);
    bus.host_addr = a;
    tick();
    check(tag, bus.host_rdata, mdl[a]);
  endtask

  // mode 0: random engine traffic, 1: full-run pattern, 2: same-address collision
  // d: cycles from dut_run to busy (> START_TO means busy never rises)
  // len: busy cycles (< 0 means busy never falls)
  // rej_at: busy-cycle index of a host write attempt (-1 for none)
  task automatic do_run(input int mode, input int d, input int len, input int rej_at);
    int                writes;
    int                waited;
    int                run0;
    int                done0;
    int                exp_cycles;
    int                exp_wc;
    logic [1:0]        exp_err;
    logic [DATA_W-1:0] exp_rd;
    logic [DATA_W-1:0] hold_rdata;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              we;
    bit                start_to;

    writes   = 0;
    run0     = run_cnt;
    done0    = done_cnt;
    start_to = (d > START_TO);

    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    check("dut_run_pulse", bus.dut_run, 1'b1);
    hold_rdata = bus.host_rdata;

    if (start_to) begin
      exp_cycles = 0;
      exp_wc     = 0;
      exp_err    = 2'b01;
    end else if (len < 0) begin
      repeat (d) tick();
      bus.dut_busy = 1'b1;
      exp_cycles   = RUN_TO;
      exp_wc       = 0;
      exp_err      = 2'b01;
    end else begin
      repeat (d) tick();
      for (int i = 0; i < len; i++) begin
        ra = ADDR_W'($urandom_range(0, 63));
        wa = ADDR_W'($urandom_range(0, 63));
        wd = DATA_W'($urandom);
        we = 1'($urandom_range(0, 1));
        if (mode == 1) begin
          if (i == 0) ra = 0;
          if (i == 1) ra = 5;
          we = (i < 14);
          wa = ADDR_W'(i);
        end else if (mode == 2) begin
          if (i < 2) ra = 7;
          if (i == 0) begin
            we = 1'b1;
            wa = 7;
            wd = 16'h1234;
          end else if (i == 1) begin
            we = 1'b0;
          end
        end
        bus.dut_busy               = 1'b1;
        bus.dut_sram_read_address  = ra;
        bus.dut_sram_write_address = wa;
        bus.dut_sram_write_data    = wd;
        bus.dut_sram_write_enable  = we;
        bus.host_we                = (i == rej_at);
        bus.host_addr              = 5;
        bus.host_wdata             = 16'hDEAD;
        exp_rd = mdl[ra];
        if (we) begin
          mdl[wa] = wd;
          writes++;
        end
        tick();
        check("eng_rdata", bus.sram_dut_read_data, exp_rd);
      end
      bus.dut_busy              = 1'b0;
      bus.dut_sram_write_enable = 1'b0;
      bus.host_we               = 1'b0;
      exp_cycles = len;
      exp_wc     = writes;
      exp_err    = {(rej_at >= 0 && rej_at < len), 1'b0};
    end

    waited = 0;
    while (bus.host_done !== 1'b1 && waited < 70000) begin
      tick();
      waited++;
    end
    check("done_seen", bus.host_done, 1'b1);
    if (start_to)     check("done_latency", waited, START_TO + 1);
    else if (len >= 0) check("done_latency", waited, 1);
    bus.dut_busy = 1'b0;

    check("host_err",    bus.host_err,    exp_err);
    check("host_cycles", bus.host_cycles, exp_cycles);
    check("host_wcount", bus.host_wcount, exp_wc);
    check("host_hold",   bus.host_rdata,  hold_rdata);
    tick();
    check("done_once",   done_cnt - done0, 1);
    check("run_once",    run_cnt - run0,   1);
    check("done_low",    bus.host_done,    1'b0);
    $display("run mode=%0d d=%0d len=%0d cycles=%0d wcount=%0d err=%b",
             mode, d, len, bus.host_cycles, bus.host_wcount, bus.host_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run"},    bus.dut_run,            1'b0);
    check({tag, "_dutrd"},  bus.sram_dut_read_data, '0);
    check({tag, "_hostrd"}, bus.host_rdata,         '0);
    check({tag, "_done"},   bus.host_done,          1'b0);
    check({tag, "_err"},    bus.host_err,           2'b00);
    check({tag, "_cyc"},    bus.host_cycles,        '0);
    check({tag, "_wc"},     bus.host_wcount,        '0);
  endtask

  initial begin
    logic [DATA_W-1:0] dut_rd_before;
    int                d;
    int                len;
    int                rej;

    reset_b                    = 1'b0;
    bus.dut_busy               = 1'b0;
    bus.dut_sram_read_address  = '0;
    bus.dut_sram_write_address = '0;
    bus.dut_sram_write_data    = '0;
    bus.dut_sram_write_enable  = 1'b0;
    bus.host_start             = 1'b0;
    bus.host_we                = 1'b0;
    bus.host_addr              = '0;
    bus.host_wdata             = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_b = 1'b1;
    tick();

    // Preload a working window, then the directed words.
    for (int a = 0; a < 64; a++) host_write(ADDR_W'(a), DATA_W'($urandom));
    host_write(0, 16'h0010);
    host_write(5, 16'hABCD);
    host_write(7, 16'h0000);

    dut_rd_before = bus.sram_dut_read_data;
    host_read("pre_rd5", 5);
    check("pre_rd5_val", bus.host_rdata, 16'hABCD);
    host_read("pre_rd0", 0);
    check("pre_dut_hold", bus.sram_dut_read_data, dut_rd_before);
    for (int k = 0; k < 6; k++) host_read("pre_rand", ADDR_W'($urandom_range(0, 63)));

    // Full run: busy 2 cycles after dut_run, 40 busy cycles, 14 writes.
    do_run(1, 2, 40, -1);
    for (int a = 0; a < 14; a++) host_read("full_rb", ADDR_W'(a));

    // Same-address collision.
    do_run(2, 1, 6, -1);
    host_read("coll_rb", 7);

    // Start timeout: busy never rises.
    do_run(0, 99, 0, -1);

    // Rejected host access during BUSY.
    do_run(0, 3, 10, 4);
    host_read("rej_rb5", 5);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      d   = $urandom_range(1, START_TO);
      len = $urandom_range(1, 25);
      rej = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      do_run(0, d, len, rej);
      for (int k = 0; k < 4; k++) host_read("rand_rb", ADDR_W'($urandom_range(0, 63)));
    end

    // Busy timeout: busy never falls.
    do_run(0, 2, -1, -1);

    // Reset in the middle of BUSY.
    host_write(5, 16'hABCD);
    bus.host_start = 1'b1;
    tick();
    bus.host_start = 1'b0;
    repeat (2) tick();
    bus.dut_busy = 1'b1;
    repeat (6) tick();
    check("midrun_cycles_nz", (bus.host_cycles != 0), 1'b1);
    reset_b = 1'b0;
    #2;
    check_reset_outputs("midrst");
    bus.dut_busy = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_run", bus.dut_run, 1'b0);
    end
    host_read("post_rst_rd5", 5);
    check("post_rst_val5", bus.host_rdata, 16'hABCD);
    check("run_never_long", run_long, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
